// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM capture path: sample width, default RAM depth
// and the capture controller state encoding.
package pdm_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int PDM_DEPTH = 32768;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RECORD,
    ST_DONE
  } pdm_state_t;

endpackage : pdm_pkg

// File: rtl/pdm_word_writer.sv
// Write side of the capture path: turns a qualified word-done strobe into a
// single-cycle RAM write at the next free address and tracks fill level.
module pdm_word_writer
  import pdm_pkg::*;
#(
  parameter int DEPTH  = PDM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_clear,
  input  logic                i_capture,
  input  logic [SAMPLE_W-1:0] i_data,
  output logic                o_we,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [SAMPLE_W-1:0] o_wdata,
  output logic [ADDR_W:0]     o_count,
  output logic                o_full
);

  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [SAMPLE_W-1:0] r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_full;

  // Issue one write per accepted word; once the last address is written the
  // full flag blocks any further captures so the address never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_clear) begin
        r_addr  <= '0;
        r_count <= '0;
        r_full  <= 1'b0;
      end else if (i_capture && !r_full) begin
        r_we    <= 1'b1;
        r_wdata <= i_data;
        r_addr  <= r_count[ADDR_W-1:0];
        r_count <= r_count + CNT_ONE;
        if (r_count == CNT_LAST) begin
          r_full <= 1'b1;
        end
      end
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_count = r_count;
  assign o_full  = r_full;

endmodule : pdm_word_writer

// File: rtl/pdm_capture_ctrl.sv
// Recording sequencer: gates the deserializer, drops the leading partial
// words after enable, and hands valid words to the RAM writer until stop or
// memory full.
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int DEPTH         = PDM_DEPTH,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int DISCARD_WORDS = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                des_done,
  input  logic [SAMPLE_W-1:0] des_data,
  output logic                des_enable,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  output logic                busy,
  output logic                full,
  output logic [ADDR_W:0]     word_count
);

  localparam int DISC_W = (DISCARD_WORDS > 0) ? $clog2(DISCARD_WORDS + 1) : 1;
  localparam logic [DISC_W-1:0] DISC_INIT = DISC_W'(DISCARD_WORDS);
  localparam logic [DISC_W-1:0] DISC_ONE  = DISC_W'(1);

  pdm_state_t        r_state;
  pdm_state_t        w_nextState;
  logic [DISC_W-1:0] r_discardCnt;
  logic              w_startAccept;
  logic              w_capture;
  logic              w_full;

  assign w_startAccept = (r_state == ST_IDLE) && start;
  assign w_capture     = (r_state == ST_RECORD) && des_done;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Discard counter: loaded on start, counts down on done pulses while arming.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_discardCnt <= '0;
    end else if (w_startAccept) begin
      r_discardCnt <= DISC_INIT;
    end else if ((r_state == ST_ARM) && des_done && (r_discardCnt != '0)) begin
      r_discardCnt <= r_discardCnt - DISC_ONE;
    end
  end

  // Next-state and status outputs; stop and full both end the pass via DONE.
  always_comb begin
    w_nextState = r_state;
    des_enable  = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_ARM;
        end
      end
      ST_ARM: begin
        des_enable = 1'b1;
        busy       = 1'b1;
        if (stop) begin
          w_nextState = ST_DONE;
        end else if (r_discardCnt == '0) begin
          w_nextState = ST_RECORD;
        end else if (des_done && (r_discardCnt == DISC_ONE)) begin
          w_nextState = ST_RECORD;
        end
      end
      ST_RECORD: begin
        des_enable = 1'b1;
        busy       = 1'b1;
        if (stop || w_full) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  pdm_word_writer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_writer (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_startAccept),
    .i_capture (w_capture),
    .i_data    (des_data),
    .o_we      (mem_we),
    .o_addr    (mem_addr),
    .o_wdata   (mem_wdata),
    .o_count   (word_count),
    .o_full    (w_full)
  );

  assign full = w_full;

endmodule : pdm_capture_ctrl

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl using a small RAM (DEPTH=8) and one
// discarded leading word.
module tb_pdm_capture_ctrl;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clock;
  logic              reset;
  logic              start;
  logic              stop;
  logic              desDone;
  logic [15:0]       desData;
  logic              desEnable;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memWdata;
  logic              busy;
  logic              full;
  logic [ADDR_W:0]   wordCount;

  int vectors = 0;
  int miscompares = 0;
  int writeCount = 0;
  int backToBack = 0;
  logic prevWe = 1'b0;
  int snap;

  pdm_capture_ctrl #(
    .DEPTH         (DEPTH),
    .ADDR_W        (ADDR_W),
    .DISCARD_WORDS (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .des_done   (desDone),
    .des_data   (desData),
    .des_enable (desEnable),
    .mem_we     (memWe),
    .mem_addr   (memAddr),
    .mem_wdata  (memWdata),
    .busy       (busy),
    .full       (full),
    .word_count (wordCount)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every RAM write and any write strobe held for two cycles in a row.
  always @(posedge clock) begin
    if (memWe) writeCount <= writeCount + 1;
    if (memWe && prevWe) backToBack <= backToBack + 1;
    prevWe <= memWe;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic [15:0] data,
                               input logic st, input logic sp);
    desDone = d;
    desData = data;
    start   = st;
    stop    = sp;
    tick();
    desDone = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic [ADDR_W-1:0] addr,
                            input logic [15:0] data);
    checkOutput({tag, " we"}, 32'(memWe), 32'd1);
    checkOutput({tag, " addr"}, 32'(memAddr), 32'(addr));
    checkOutput({tag, " data"}, 32'(memWdata), 32'(data));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; desDone = 1'b0; desData = '0;
    $display("[TB] starting pdm_capture_ctrl bench");
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset values.
    checkOutput("rst des_enable", 32'(desEnable), 32'd0);
    checkOutput("rst mem_we", 32'(memWe), 32'd0);
    checkOutput("rst mem_addr", 32'(memAddr), 32'd0);
    checkOutput("rst mem_wdata", 32'(memWdata), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst full", 32'(full), 32'd0);
    checkOutput("rst word_count", 32'(wordCount), 32'd0);

    // Idle with done pulses every 16 cycles: nothing may be written.
    snap = writeCount;
    for (int i = 0; i < 64; i++) begin
      applyStimulus((i % 16) == 15, 16'hFFFF, 1'b0, 1'b0);
      if (i == 47) checkOutput("idle des_enable", 32'(desEnable), 32'd0);
    end
    idle(2);
    checkOutput("idle writes", 32'(writeCount - snap), 32'd0);
    checkOutput("idle word_count", 32'(wordCount), 32'd0);

    // Start: first word discarded, then two writes.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("arm busy", 32'(busy), 32'd1);
    checkOutput("arm des_enable", 32'(desEnable), 32'd1);
    idle(2);
    applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b0);
    checkOutput("discard no we", 32'(memWe), 32'd0);
    idle(3);
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
    checkWrite("w0", 3'd0, 16'h0001);
    checkOutput("w0 count", 32'(wordCount), 32'd1);
    idle(3);
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    checkWrite("w1", 3'd1, 16'h1234);
    idle(3);
    checkOutput("two words", 32'(wordCount), 32'd2);

    // Start during RECORD is ignored; recording continues at address 2.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("rec start busy", 32'(busy), 32'd1);
    checkOutput("rec start count", 32'(wordCount), 32'd2);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    checkWrite("w2", 3'd2, 16'h5555);
    idle(2);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("stop busy", 32'(busy), 32'd0);
    checkOutput("stop des_enable", 32'(desEnable), 32'd0);
    // Start while in DONE is ignored; the block falls back to IDLE.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("done start busy", 32'(busy), 32'd0);
    idle(2);
    checkOutput("done start busy2", 32'(busy), 32'd0);
    checkOutput("held count", 32'(wordCount), 32'd3);

    // Fill memory: exactly DEPTH writes, then full and disable.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("fill count clr", 32'(wordCount), 32'd0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
    idle(3);
    snap = writeCount;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
      checkWrite("fill", ADDR_W'(i), 16'h1000 + 16'(i));
      if (i < DEPTH - 1) idle(3);
    end
    checkOutput("fill full", 32'(full), 32'd1);
    tick();
    checkOutput("fill des_enable", 32'(desEnable), 32'd0);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    idle(3);
    checkOutput("fill writes", 32'(writeCount - snap), 32'(DEPTH));
    checkOutput("fill word_count", 32'(wordCount), 32'(DEPTH));
    checkOutput("fill full held", 32'(full), 32'd1);

    // Stop coincident with the word carrying BEEF at index 3.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("stop full clr", 32'(full), 32'd0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
      idle(3);
    end
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b1);
    checkWrite("beef", 3'd3, 16'hBEEF);
    checkOutput("beef des_enable", 32'(desEnable), 32'd0);
    checkOutput("beef count", 32'(wordCount), 32'd4);
    checkOutput("beef full", 32'(full), 32'd0);
    tick();
    checkOutput("beef we drop", 32'(memWe), 32'd0);

    // Reset coincident with a done pulse abandons the write.
    idle(2);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0);
    idle(3);
    snap = writeCount;
    reset = 1'b1;
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rstw mem_we", 32'(memWe), 32'd0);
    checkOutput("rstw mem_addr", 32'(memAddr), 32'd0);
    checkOutput("rstw mem_wdata", 32'(memWdata), 32'd0);
    checkOutput("rstw des_enable", 32'(desEnable), 32'd0);
    checkOutput("rstw busy", 32'(busy), 32'd0);
    checkOutput("rstw word_count", 32'(wordCount), 32'd0);
    idle(2);
    checkOutput("rstw writes", 32'(writeCount - snap), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b1, 16'h4242, 1'b0, 1'b0);
    checkWrite("after rst", 3'd0, 16'h4242);
    checkOutput("after rst count", 32'(wordCount), 32'd1);
    idle(2);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    idle(2);

    checkOutput("we back-to-back", 32'(backToBack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pdm_capture_ctrl
